mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL use the corePckg types tAluOut, tMemOp and tRegOp, with cXLEN = 32 and cRegSelBitW = 5.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports as follows (name, direction, width, meaning):
- iClk, in, 1: clock, rising edge.
- iRstn, in, 1: asynchronous active-low reset.
- iAluOut, in, tAluOut: result from the ALU stage; memOp and regOp are used, brchOp is ignored.
- iValid, in, 1: iAluOut is valid this cycle.
- oReady, out, 1: stage accepts iAluOut this cycle.
- oMemReq, out, 1: data-memory request.
- oMemWe, out, 1: request is a write.
- oMemAddr, out, 32: word-aligned address, {addr[31:2], 2'b00}.
- oMemWData, out, 32: lane-replicated store data.
- oMemBe, out, 4: byte enables.
- iMemGnt, in, 1: memory accepts the request this cycle.
- iMemRValid, in, 1: read data is valid.
- iMemRData, in, 32: read word.
- oRegOp, out, tRegOp: writeback to the register file.
- oErr, out, 1: one-cycle pulse for an illegal or misaligned access.

Function
REQ-004 SHALL implement an FSM with states IDLE, REQ and RDWAIT.
REQ-005 SHALL drive oReady = 1 only in IDLE; oReady is combinational from state.
REQ-006 SHALL take a transfer only when iValid and oReady are both high; iAluOut is captured on that edge.
REQ-007 SHALL register the passthrough for a transfer with memOp.read = 0 and memOp.write = 0: oRegOp equals iAluOut.regOp in the next cycle (latency 1), and the FSM stays in IDLE.
REQ-008 SHALL decode opType as follows:
- read: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- write: 000 SB, 001 SH, 010 SW.
REQ-009 SHALL pulse oErr for one cycle, issue no memory request, keep oRegOp.dv = 0 and stay in IDLE when any of these holds:
- read and write are both set;
- opType is undefined;
- halfword access with addr[0] = 1;
- word access with addr[1:0] != 0.
REQ-010 SHALL, for a legal memory transfer, enter REQ on the next edge and drive oMemReq = 1 from the following cycle.
REQ-011 SHALL hold oMemReq, oMemWe, oMemAddr, oMemWData and oMemBe stable in REQ until a cycle with iMemGnt = 1.
REQ-012 SHALL generate store lanes as follows:
- SB: byte replicated to all 4 lanes, oMemBe = 4'b0001 << addr[1:0].
- SH: halfword replicated to both halves, oMemBe = 4'b0011 << addr[1:0].
- SW: full word, oMemBe = 4'b1111.
REQ-013 SHALL drive oMemBe = 4'b1111 for reads.
REQ-014 SHALL, on iMemGnt in REQ, drop oMemReq on the next edge and go to:
- IDLE for a write, with no register write;
- RDWAIT for a read.
REQ-015 SHALL, on iMemRValid in RDWAIT:
- select the byte or halfword by the captured addr[1:0];
- sign-extend for LB/LH, zero-extend for LBU/LHU, pass the word through for LW;
- drive oRegOp = {dv = 1, addr = rdAddr, data = extended} in the next cycle;
- return to IDLE.
REQ-016 SHALL force oRegOp.dv = 0 when rdAddr = 0, for both loads and passthrough.
REQ-017 SHALL hold oRegOp.dv for exactly one cycle per retired instruction; it is 0 otherwise, and addr/data hold their last values.
REQ-018 SHALL ignore iMemRValid outside RDWAIT, and SHALL ignore iMemGnt outside REQ.
REQ-019 SHALL ignore iValid while oReady = 0; the upstream stage holds iAluOut.

Reset
REQ-020 SHALL, while iRstn = 0, immediately force:
- state = IDLE;
- oMemReq = 0, oMemWe = 0, oMemAddr = 0, oMemWData = 0, oMemBe = 0;
- oRegOp = 0, oErr = 0.
REQ-021 SHALL drive oReady = 1 during reset and after reset release, because state = IDLE.
REQ-022 SHALL abandon an outstanding request or read on reset mid-operation, with no writeback and no oErr afterwards.

Verification
REQ-023 Passthrough: regOp = {1, 5, 0xDEADBEEF}, no memOp -> oRegOp = {1, 5, 0xDEADBEEF} exactly 1 cycle later; oMemReq stays 0.
REQ-024 LB: addr = 0x1003, rdAddr = 7, iMemRData = 0x80FF_FFFF, grant after 2 wait cycles -> oMemAddr = 0x1000, oRegOp = {1, 7, 0xFFFFFF80}; the same case with LBU -> 0x00000080.
REQ-025 SH: addr = 0x2002, data = 0x0000ABCD -> oMemWData = 0xABCDABCD, oMemBe = 4'b1100, oMemWe = 1, held until grant; no oRegOp.dv.
REQ-026 Misaligned: LW at addr = 0x3001 -> oErr pulses 1 cycle; no oMemReq; oReady stays 1.
REQ-027 Back-pressure: second iValid while in RDWAIT -> oReady = 0 and the transfer is not taken; it is accepted in the cycle after writeback.
REQ-028 Reset: iRstn low in RDWAIT -> all outputs go to 0 asynchronously; a later iMemRValid produces no writeback.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory access stage: load/store issue, grant/rvalid handshake, load extension.
// Non-memory instructions pass through with one cycle of latency.
package corePckg;
  localparam int cXLEN = 32;
  localparam int cRegSelBitW = 5;

  typedef struct packed {
    logic             read;
    logic             write;
    logic [2:0]       opType;
    logic [cXLEN-1:0] addr;
    logic [cXLEN-1:0] data;
  } tMemOp;

  typedef struct packed {
    logic                   dv;
    logic [cRegSelBitW-1:0] addr;
    logic [cXLEN-1:0]       data;
  } tRegOp;

  typedef struct packed {
    logic             taken;
    logic [cXLEN-1:0] target;
  } tBrchOp;

  typedef struct packed {
    tMemOp  memOp;
    tRegOp  regOp;
    tBrchOp brchOp;
  } tAluOut;
endpackage

module mem_access_stage
  import corePckg::*;
(
  input  logic        iClk,
  input  logic        iRstn,
  input  tAluOut      iAluOut,
  input  logic        iValid,
  output logic        oReady,
  output logic        oMemReq,
  output logic        oMemWe,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemWData,
  output logic [3:0]  oMemBe,
  input  logic        iMemGnt,
  input  logic        iMemRValid,
  input  logic [31:0] iMemRData,
  output tRegOp       oRegOp,
  output logic        oErr
);

  typedef enum logic [1:0] {IDLE, REQ, RDWAIT} tState;

  tState      state;
  logic [2:0] ld_op;
  logic [1:0] ld_off;
  logic [4:0] ld_rd;

  tMemOp       mo;
  logic        take;
  logic        is_mem;
  logic        legal_rd;
  logic        legal_wr;
  logic        misal;
  logic        err;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val;
  logic        unused;

  assign unused = ^iAluOut.brchOp;

  assign oReady = (state == IDLE);
  assign mo     = iAluOut.memOp;
  assign take   = iValid && oReady;
  assign is_mem = mo.read || mo.write;

  assign legal_rd = (mo.opType inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign legal_wr = (mo.opType inside {3'b000, 3'b001, 3'b010});
  assign misal = ((mo.opType[1:0] == 2'b01) && mo.addr[0]) ||
                 ((mo.opType[1:0] == 2'b10) && (mo.addr[1:0] != 2'b00));
  assign err = (mo.read && mo.write) ||
               (mo.read && !legal_rd) ||
               (mo.write && !legal_wr) ||
               (is_mem && misal);

  always_comb begin
    st_data = mo.data;
    st_be   = 4'b1111;
    unique case (1'b1)
      (mo.opType[1:0] == 2'b00): begin
        st_data = {4{mo.data[7:0]}};
        st_be   = 4'b0001 << mo.addr[1:0];
      end
      (mo.opType[1:0] == 2'b01): begin
        st_data = {2{mo.data[15:0]}};
        st_be   = 4'b0011 << mo.addr[1:0];
      end
      default: begin
        st_data = mo.data;
        st_be   = 4'b1111;
      end
    endcase
  end

  // ld_op[2] marks the unsigned variants
  always_comb begin
    ld_b   = 8'(iMemRData >> {ld_off, 3'b000});
    ld_h   = ld_off[1] ? iMemRData[31:16] : iMemRData[15:0];
    ld_val = iMemRData;
    unique case (1'b1)
      (ld_op[1:0] == 2'b00): ld_val = {{24{~ld_op[2] & ld_b[7]}}, ld_b};
      (ld_op[1:0] == 2'b01): ld_val = {{16{~ld_op[2] & ld_h[15]}}, ld_h};
      default:               ld_val = iMemRData;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state     <= IDLE;
      oMemReq   <= 1'b0;
      oMemWe    <= 1'b0;
      oMemAddr  <= '0;
      oMemWData <= '0;
      oMemBe    <= '0;
      oRegOp    <= '0;
      oErr      <= 1'b0;
      ld_op     <= '0;
      ld_off    <= '0;
      ld_rd     <= '0;
    end else begin
      oErr      <= 1'b0;
      oRegOp.dv <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            if (err) begin
              oErr <= 1'b1;
            end else if (is_mem) begin
              state     <= REQ;
              oMemReq   <= 1'b1;
              oMemWe    <= mo.write;
              oMemAddr  <= {mo.addr[31:2], 2'b00};
              oMemWData <= st_data;
              oMemBe    <= mo.write ? st_be : 4'b1111;
              ld_op     <= mo.opType;
              ld_off    <= mo.addr[1:0];
              ld_rd     <= iAluOut.regOp.addr;
            end else begin
              oRegOp.dv   <= iAluOut.regOp.dv &&
                             (iAluOut.regOp.addr != '0);
              oRegOp.addr <= iAluOut.regOp.addr;
              oRegOp.data <= iAluOut.regOp.data;
            end
          end
        end
        REQ: begin
          if (iMemGnt) begin
            oMemReq <= 1'b0;
            state   <= oMemWe ? IDLE : RDWAIT;
          end
        end
        RDWAIT: begin
          if (iMemRValid) begin
            oRegOp.dv   <= (ld_rd != '0);
            oRegOp.addr <= ld_rd;
            oRegOp.data <= ld_val;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus random traffic
// against an arithmetic reference model.
module tb_mem_access_stage;
  import corePckg::*;

  logic        iClk;
  logic        iRstn;
  tAluOut      iAluOut;
  logic        iValid;
  logic        oReady;
  logic        oMemReq;
  logic        oMemWe;
  logic [31:0] oMemAddr;
  logic [31:0] oMemWData;
  logic [3:0]  oMemBe;
  logic        iMemGnt;
  logic        iMemRValid;
  logic [31:0] iMemRData;
  tRegOp       oRegOp;
  logic        oErr;

  int checks = 0;
  int errors = 0;

  mem_access_stage dut (
    .iClk(iClk), .iRstn(iRstn), .iAluOut(iAluOut), .iValid(iValid),
    .oReady(oReady), .oMemReq(oMemReq), .oMemWe(oMemWe),
    .oMemAddr(oMemAddr), .oMemWData(oMemWData), .oMemBe(oMemBe),
    .iMemGnt(iMemGnt), .iMemRValid(iMemRValid), .iMemRData(iMemRData),
    .oRegOp(oRegOp), .oErr(oErr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic tAluOut mk(bit rd, bit wr, int op, logic [31:0] a,
                                logic [31:0] d, bit rdv, int rdi,
                                logic [31:0] rdat);
    tAluOut t;
    t = '0;
    t.memOp.read   = rd;
    t.memOp.write  = wr;
    t.memOp.opType = 3'(op);
    t.memOp.addr   = a;
    t.memOp.data   = d;
    t.regOp.dv     = rdv;
    t.regOp.addr   = 5'(rdi);
    t.regOp.data   = rdat;
    t.brchOp.taken  = 1'($urandom);
    t.brchOp.target = $urandom;
    return t;
  endfunction

  function automatic bit m_err(tMemOp m);
    int op;
    int sz;
    int off;
    op  = int'(m.opType);
    sz  = op % 4;
    off = int'(m.addr % 4);
    if (m.read && m.write) return 1;
    if (m.read && !(op == 0 || op == 1 || op == 2 || op == 4 || op == 5))
      return 1;
    if (m.write && op > 2) return 1;
    if (sz == 1 && off % 2 != 0) return 1;
    if (sz == 2 && off != 0) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_load(int op, logic [31:0] a,
                                          logic [31:0] rdat);
    logic [31:0] v;
    int off;
    off = int'(a % 4);
    if (op % 4 == 0) begin
      v = (rdat >> (8 * off)) % 256;
      if (op < 4 && v >= 128) v = v - 256;
    end else if (op % 4 == 1) begin
      v = (rdat >> (16 * (off / 2))) % 65536;
      if (op < 4 && v >= 32768) v = v - 65536;
    end else begin
      v = rdat;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_be(tMemOp m);
    int off;
    off = int'(m.addr % 4);
    if (m.read) return 4'd15;
    if (m.opType == 3'd0) return 4'(1 << off);
    if (m.opType == 3'd1) return 4'(3 << off);
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(tMemOp m);
    if (m.opType == 3'd0) return (m.data % 256) * 32'h0101_0101;
    if (m.opType == 3'd1) return (m.data % 65536) * 32'h0001_0001;
    return m.data;
  endfunction

  task automatic do_txn(tAluOut a, int gw, int rw, logic [31:0] rdat);
    tMemOp m;
    logic [31:0] wa;
    m  = a.memOp;
    wa = m.addr - (m.addr % 4);
    chk("ready_idle", oReady, 1);
    iAluOut = a;
    iValid  = 1'b1;
    step();
    iValid = 1'b0;
    if (!m.read && !m.write) begin
      chk("pt_dv", oRegOp.dv, a.regOp.dv && a.regOp.addr != 0);
      if (a.regOp.dv && a.regOp.addr != 0) begin
        chk("pt_addr", oRegOp.addr, a.regOp.addr);
        chk("pt_data", oRegOp.data, a.regOp.data);
      end
      chk("pt_req", oMemReq, 0);
      chk("pt_err", oErr, 0);
      chk("pt_ready", oReady, 1);
    end else if (m_err(m)) begin
      chk("err_pulse", oErr, 1);
      chk("err_req", oMemReq, 0);
      chk("err_dv", oRegOp.dv, 0);
      chk("err_ready", oReady, 1);
      step();
      chk("err_clear", oErr, 0);
      chk("err_req2", oMemReq, 0);
    end else begin
      chk("req", oMemReq, 1);
      chk("req_we", oMemWe, m.write);
      chk("req_addr", oMemAddr, wa);
      chk("req_be", oMemBe, m_be(m));
      if (m.write) chk("req_wdata", oMemWData, m_wdata(m));
      chk("req_ready", oReady, 0);
      repeat (gw) begin
        iMemRValid = 1'($urandom);
        step();
        chk("hold_req", oMemReq, 1);
        chk("hold_addr", oMemAddr, wa);
        chk("hold_be", oMemBe, m_be(m));
        chk("hold_dv", oRegOp.dv, 0);
      end
      iMemRValid = 1'b0;
      iMemGnt    = 1'b1;
      step();
      iMemGnt = 1'b0;
      chk("gnt_drop", oMemReq, 0);
      if (m.write) begin
        chk("wr_dv", oRegOp.dv, 0);
        chk("wr_ready", oReady, 1);
      end else begin
        chk("rd_wait_ready", oReady, 0);
        repeat (rw) begin
          iMemGnt = 1'($urandom);
          step();
          chk("rd_wait_dv", oRegOp.dv, 0);
          chk("rd_wait_ready2", oReady, 0);
        end
        iMemGnt    = 1'b0;
        iMemRValid = 1'b1;
        iMemRData  = rdat;
        step();
        iMemRValid = 1'b0;
        chk("ld_dv", oRegOp.dv, a.regOp.addr != 0);
        if (a.regOp.addr != 0) begin
          chk("ld_addr", oRegOp.addr, a.regOp.addr);
          chk("ld_data", oRegOp.data, m_load(int'(m.opType), m.addr, rdat));
        end
        chk("ld_ready", oReady, 1);
      end
    end
    step();
    chk("dv_one_cycle", oRegOp.dv, 0);
  endtask

  initial begin
    tAluOut t;
    iRstn      = 1'b0;
    iValid     = 1'b0;
    iAluOut    = '0;
    iMemGnt    = 1'b0;
    iMemRValid = 1'b0;
    iMemRData  = '0;
    #12;
    chk("rst_ready", oReady, 1);
    chk("rst_req", oMemReq, 0);
    chk("rst_regop", oRegOp, 0);
    chk("rst_be", oMemBe, 0);
    chk("rst_err", oErr, 0);
    @(posedge iClk);
    #1;
    iRstn = 1'b1;
    step();

    // passthrough
    do_txn(mk(0, 0, 0, 32'h0, 32'h0, 1, 5, 32'hDEAD_BEEF), 0, 0, 0);
    do_txn(mk(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h1111_2222), 0, 0, 0);

    // LB / LBU at 0x1003 with two wait cycles
    do_txn(mk(1, 0, 0, 32'h1003, 0, 0, 7, 0), 2, 1, 32'h80FF_FFFF);
    chk("lb_const", oRegOp.data, 32'hFFFF_FF80);
    do_txn(mk(1, 0, 4, 32'h1003, 0, 0, 7, 0), 2, 1, 32'h80FF_FFFF);
    chk("lbu_const", oRegOp.data, 32'h0000_0080);

    // SH at 0x2002
    do_txn(mk(0, 1, 1, 32'h2002, 32'h0000_ABCD, 0, 0, 0), 3, 0, 0);
    chk("sh_wdata_const", oMemWData, 32'hABCD_ABCD);
    chk("sh_be_const", oMemBe, 4'b1100);

    // misaligned LW, illegal op, read+write
    do_txn(mk(1, 0, 2, 32'h3001, 0, 0, 4, 0), 0, 0, 0);
    do_txn(mk(1, 0, 3, 32'h3000, 0, 0, 4, 0), 0, 0, 0);
    do_txn(mk(1, 1, 2, 32'h3000, 0, 0, 4, 0), 0, 0, 0);

    // back-pressure: LH in flight, passthrough held upstream
    t = mk(1, 0, 1, 32'h5002, 0, 0, 9, 0);
    iAluOut = t;
    iValid  = 1'b1;
    step();
    iAluOut = mk(0, 0, 0, 0, 0, 1, 10, 32'h1234_5678);
    chk("bp_ready_req", oReady, 0);
    iMemGnt = 1'b1;
    step();
    iMemGnt = 1'b0;
    repeat (2) begin
      chk("bp_ready_rd", oReady, 0);
      chk("bp_dv", oRegOp.dv, 0);
      step();
    end
    iMemRValid = 1'b1;
    iMemRData  = 32'h8001_0000;
    step();
    iMemRValid = 1'b0;
    chk("bp_ld_dv", oRegOp.dv, 1);
    chk("bp_ld_data", oRegOp.data, 32'hFFFF_8001);
    chk("bp_ready_wb", oReady, 1);
    step();
    iValid = 1'b0;
    chk("bp_pt_dv", oRegOp.dv, 1);
    chk("bp_pt_addr", oRegOp.addr, 5'd10);
    chk("bp_pt_data", oRegOp.data, 32'h1234_5678);
    step();

    // asynchronous reset while waiting for read data
    iAluOut = mk(1, 0, 2, 32'h4000, 0, 0, 3, 0);
    iValid  = 1'b1;
    step();
    iValid  = 1'b0;
    iMemGnt = 1'b1;
    step();
    iMemGnt = 1'b0;
    chk("ar_rdwait", oReady, 0);
    #2;
    iRstn = 1'b0;
    #1;
    chk("ar_ready", oReady, 1);
    chk("ar_addr", oMemAddr, 0);
    chk("ar_be", oMemBe, 0);
    chk("ar_we", oMemWe, 0);
    chk("ar_regop", oRegOp, 0);
    @(posedge iClk);
    #1;
    iRstn      = 1'b1;
    iMemRValid = 1'b1;
    iMemRData  = 32'hFFFF_FFFF;
    step();
    iMemRValid = 1'b0;
    chk("ar_no_wb", oRegOp.dv, 0);
    chk("ar_no_err", oErr, 0);
    step();
    chk("ar_no_wb2", oRegOp.dv, 0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      int k;
      logic [31:0] a;
      k = int'($urandom_range(0, 9));
      a = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
      t = mk(k >= 2 && k <= 5 || k == 9, k >= 6, int'($urandom_range(0, 7)),
             a, $urandom, 1'($urandom), int'($urandom_range(0, 31)),
             $urandom);
      do_txn(t, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
